// File: rtl/pipelined_cpa.sv
// Pipelined carry-propagate adder: STAGES slices of WIDTH/STAGES bits, one slice per stage.
// Define PIPELINED_CPA_SUB_EN to add a 'sub' port selecting a-b instead of a+b+c_in.
`timescale 1ns/1ps

module pipelined_cpa #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef PIPELINED_CPA_SUB_EN
   input  logic             sub,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned K = WIDTH / STAGES;
   localparam int unsigned L = STAGES - 1;

   if (WIDTH < 4 || WIDTH > 64) begin : gen_width_chk
      $error("pipelined_cpa: WIDTH must lie in 4..64");
   end
   if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : gen_stage_chk
      $error("pipelined_cpa: WIDTH must be divisible by STAGES");
   end

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

`ifdef PIPELINED_CPA_SUB_EN
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub | c_in;
`else
   assign b_eff   = b;
   assign cin_eff = c_in;
`endif

   // Per-stage state; a_q/b_q carry the operands so later stages see their own slice.
   logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, sum_q;
   logic [STAGES-1:0]            cy_q, vld_q;

   logic [STAGES-1:0][WIDTH-1:0] prev_a, prev_b, prev_sum, sum_d;
   logic [STAGES-1:0]            prev_cy, prev_vld, cy_d;
   logic [K:0]                   slice;
   logic                         adv;

   always_comb begin
      slice       = '0;
      prev_a[0]   = a;
      prev_b[0]   = b_eff;
      prev_sum[0] = '0;
      prev_cy[0]  = cin_eff;
      prev_vld[0] = in_valid;
      for (int unsigned i = 1; i < STAGES; i++) begin
         prev_a[i]   = a_q[i-1];
         prev_b[i]   = b_q[i-1];
         prev_sum[i] = sum_q[i-1];
         prev_cy[i]  = cy_q[i-1];
         prev_vld[i] = vld_q[i-1];
      end
      for (int unsigned i = 0; i < STAGES; i++) begin
         slice = {1'b0, prev_a[i][i*K +: K]} + {1'b0, prev_b[i][i*K +: K]}
               + {{K{1'b0}}, prev_cy[i]};
         sum_d[i]            = prev_sum[i];
         sum_d[i][i*K +: K]  = slice[K-1:0];
         cy_d[i]             = slice[K];
      end
   end

   // The whole pipe, bubbles included, moves only when the output slot can drain.
   assign adv      = !(out_valid && !out_ready);
   assign in_ready = adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         sum_q <= '0;
         cy_q  <= '0;
         vld_q <= '0;
      end else if (adv) begin
         a_q   <= prev_a;
         b_q   <= prev_b;
         sum_q <= sum_d;
         cy_q  <= cy_d;
         vld_q <= prev_vld;
      end
   end

   assign s         = sum_q[L];
   assign c_out     = cy_q[L];
   assign out_valid = vld_q[L];
   assign ovf       = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) &&
                      (sum_q[L][WIDTH-1] != a_q[L][WIDTH-1]);

   // Only the sign bits of the last stage's operands matter; the rest trims away.
   logic unused_op_bits;
   assign unused_op_bits = ^{a_q[L][WIDTH-2:0], b_q[L][WIDTH-2:0]};

endmodule

// File: tb/tb_pipelined_cpa.sv
// Scoreboard bench for pipelined_cpa (WIDTH=16, STAGES=4): directed cases, stall, reset, random burst.
`timescale 1ns/1ps

module tb_pipelined_cpa;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a, b, s;
   logic        c_in, sub, in_valid, in_ready, c_out, ovf, out_valid, out_ready;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [17:0] sb[$];

   pipelined_cpa #(.WIDTH(16), .STAGES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
`ifdef PIPELINED_CPA_SUB_EN
      .sub       (sub),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .s         (s),
      .c_out     (c_out),
      .ovf       (ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // {c_out, ovf, s}
   function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb_,
                                         input logic tc, input logic ts);
      logic [15:0] be;
      logic        ce, o;
      logic [16:0] r;
      be = ts ? ~tb_ : tb_;
      ce = ts ? 1'b1 : tc;
      r  = {1'b0, ta} + {1'b0, be} + {16'd0, ce};
      o  = (ta[15] == be[15]) && (r[15] != ta[15]);
      return {r[16], o, r[15:0]};
   endfunction

   task automatic step(input logic v, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, input logic ts);
      in_valid = v;
      a        = ta;
      b        = tb_;
      c_in     = tc;
      sub      = ts;
      #1;
      if (v && in_ready) sb.push_back(model(ta, tb_, tc, ts));
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         logic [17:0] exp;
         exp = (sb.size() > 0) ? sb.pop_front() : 18'bx;
         chk("result", 32'({c_out, ovf, s}), 32'(exp));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_c_out", 32'(c_out), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);

      // 1+1 with latency check
      step(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
      for (int n = 1; n <= 4; n++) begin
         chk("latency_out_valid", 32'(out_valid), 32'(n == 4));
         step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      end

      // Full ripple and signed overflow
      step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
      step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      drain(6);

      // Back-to-back with a 3-cycle stall on the first result
      step(1'b1, 16'd1, 16'd1, 1'b0, 1'b0);
      step(1'b1, 16'd2, 16'd2, 1'b0, 1'b0);
      step(1'b1, 16'd3, 16'd3, 1'b0, 1'b0);
      step(1'b1, 16'd4, 16'd4, 1'b0, 1'b0);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_s_held", 32'(s), 32'h0002);
         step(1'b1, 16'd5, 16'd5, 1'b0, 1'b0);
      end
      out_ready = 1'b1;
      step(1'b1, 16'd5, 16'd5, 1'b0, 1'b0);
      drain(8);
      chk("b2b_drained", 32'(sb.size()), 32'd0);

      // Reset with two sets in flight
      step(1'b1, 16'h0010, 16'h0010, 1'b0, 1'b0);
      step(1'b1, 16'h0020, 16'h0020, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      sb.delete();
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_s", 32'(s), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         #1;
         chk("no_stale_out_valid", 32'(out_valid), 32'd0);
         step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      end
      step(1'b1, 16'h1234, 16'h0101, 1'b1, 1'b0);
      for (int n = 1; n <= 4; n++) begin
         chk("post_rst_latency", 32'(out_valid), 32'(n == 4));
         step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      end

`ifdef PIPELINED_CPA_SUB_EN
      step(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1);
      step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
      step(1'b1, 16'h0009, 16'h0003, 1'b0, 1'b0);
      drain(6);
`endif

      // Random traffic with random back-pressure
      for (int i = 0; i < 80; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef PIPELINED_CPA_SUB_EN
         step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
`else
         step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
`endif
      end
      out_ready = 1'b1;
      drain(10);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
